// File: rtl/game_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_sequencer
//  Description : Game-flow controller for the lane/obstacle datapath. Runs
//                the idle -> play -> hit-freeze / level-pause -> game-over
//                round sequence and owns lives, score and lane speeds.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_round_sequencer #(
  parameter int LIVES_INIT  = 3,
  parameter int SPEED1_INIT = 5,
  parameter int SPEED2_INIT = 3,
  parameter int SPEED3_INIT = 4,
  parameter int SPEED4_INIT = 4,
  parameter int SPEED_STEP  = 2,
  parameter int SPEED_MAX   = 15,
  parameter int HIT_FREEZE  = 60,
  parameter int LEVEL_PAUSE = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       hit,
  input  logic       finish,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic [3:0] score,
  output logic [3:0] speed1,
  output logic [3:0] speed2,
  output logic [3:0] speed3,
  output logic [3:0] speed4,
  output logic       motion_en,
  output logic       respawn,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_LEVEL = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] c_lives_init = 2'(LIVES_INIT);
  localparam logic [3:0] c_speed1     = 4'(SPEED1_INIT);
  localparam logic [3:0] c_speed2     = 4'(SPEED2_INIT);
  localparam logic [3:0] c_speed3     = 4'(SPEED3_INIT);
  localparam logic [3:0] c_speed4     = 4'(SPEED4_INIT);
  localparam logic [4:0] c_step       = 5'(SPEED_STEP);
  localparam logic [4:0] c_max        = 5'(SPEED_MAX);
  localparam logic [7:0] c_hit_freeze = 8'(HIT_FREEZE);
  localparam logic [7:0] c_lvl_pause  = 8'(LEVEL_PAUSE);

  state_t     r_state;
  logic [7:0] r_timer;
  logic       r_start_q;

  state_t     w_state_nx;
  logic [7:0] w_timer_nx;
  logic [1:0] w_lives_nx;
  logic [3:0] w_score_nx;
  logic [3:0] w_speed1_nx;
  logic [3:0] w_speed2_nx;
  logic [3:0] w_speed3_nx;
  logic [3:0] w_speed4_nx;
  logic       w_motion_nx;
  logic       w_respawn_nx;
  logic       w_over_nx;
  logic       w_start_rise;

  // Speed bump with 5-bit headroom so the sum cannot wrap before clamping.
  function automatic logic [3:0] speed_up(input logic [3:0] s);
    logic [4:0] sum;
    sum = {1'b0, s} + c_step;
    if (sum > c_max) begin
      return c_max[3:0];
    end
    return sum[3:0];
  endfunction

  // start_q resets high so a button held through reset cannot start a game.
  assign w_start_rise = start & ~r_start_q;
  assign state        = r_state;

  // State, timer, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= 8'd0;
      r_start_q <= 1'b1;
      lives     <= c_lives_init;
      score     <= 4'd0;
      speed1    <= c_speed1;
      speed2    <= c_speed2;
      speed3    <= c_speed3;
      speed4    <= c_speed4;
      motion_en <= 1'b0;
      respawn   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_timer   <= w_timer_nx;
      r_start_q <= start;
      lives     <= w_lives_nx;
      score     <= w_score_nx;
      speed1    <= w_speed1_nx;
      speed2    <= w_speed2_nx;
      speed3    <= w_speed3_nx;
      speed4    <= w_speed4_nx;
      motion_en <= w_motion_nx;
      respawn   <= w_respawn_nx;
      game_over <= w_over_nx;
    end
  end

  // Round sequencing: next state and next values of every registered output.
  always_comb begin
    w_state_nx   = r_state;
    w_timer_nx   = r_timer;
    w_lives_nx   = lives;
    w_score_nx   = score;
    w_speed1_nx  = speed1;
    w_speed2_nx  = speed2;
    w_speed3_nx  = speed3;
    w_speed4_nx  = speed4;
    w_respawn_nx = 1'b0;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_rise) begin
          w_lives_nx   = c_lives_init;
          w_score_nx   = 4'd0;
          w_speed1_nx  = c_speed1;
          w_speed2_nx  = c_speed2;
          w_speed3_nx  = c_speed3;
          w_speed4_nx  = c_speed4;
          w_respawn_nx = 1'b1;
          w_state_nx   = S_PLAY;
        end
      end
      S_PLAY: begin
        // A collision outranks reaching the finish row in the same cycle.
        if (hit) begin
          if (lives > 2'd1) begin
            w_lives_nx = lives - 2'd1;
            w_timer_nx = c_hit_freeze;
            w_state_nx = S_HIT;
          end else begin
            w_lives_nx = 2'd0;
            w_state_nx = S_OVER;
          end
        end else if (finish) begin
          w_score_nx  = (score == 4'hF) ? score : score + 4'd1;
          w_speed1_nx = speed_up(speed1);
          w_speed2_nx = speed_up(speed2);
          w_speed3_nx = speed_up(speed3);
          w_speed4_nx = speed_up(speed4);
          w_timer_nx  = c_lvl_pause;
          w_state_nx  = S_LEVEL;
        end
      end
      S_HIT, S_LEVEL: begin
        // A zero timer here is unreachable; treating it as expiry avoids a lockup.
        if (tick) begin
          if (r_timer <= 8'd1) begin
            w_timer_nx   = 8'd0;
            w_respawn_nx = 1'b1;
            w_state_nx   = S_PLAY;
          end else begin
            w_timer_nx = r_timer - 8'd1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    w_motion_nx = (w_state_nx == S_PLAY);
    w_over_nx   = (w_state_nx == S_OVER);
  end

endmodule
`default_nettype wire

// File: tb/tb_game_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_round_sequencer
//  Description : Directed self-checking bench for game_round_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_round_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       finish = 1'b0;
  logic [2:0] state;
  logic [1:0] lives;
  logic [3:0] score;
  logic [3:0] speed1, speed2, speed3, speed4;
  logic       motion_en, respawn, game_over;

  int checks   = 0;
  int failures = 0;

  int e_sp1, e_sp2, e_sp3, e_sp4, e_score;

  game_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .hit       (hit),
    .finish    (finish),
    .state     (state),
    .lives     (lives),
    .score     (score),
    .speed1    (speed1),
    .speed2    (speed2),
    .speed3    (speed3),
    .speed4    (speed4),
    .motion_en (motion_en),
    .respawn   (respawn),
    .game_over (game_over)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic press_start();
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
  endtask

  // Full freeze after a hit: 59 ticks stay in HIT, the 60th respawns.
  task automatic ride_freeze(input string tag);
    ticks(59);
    check({tag, "_still_hit"}, int'(state), 2);
    check({tag, "_no_early_respawn"}, int'(respawn), 0);
    ticks(1);
    check({tag, "_back_play"}, int'(state), 1);
    check({tag, "_respawn"}, int'(respawn), 1);
    check({tag, "_motion"}, int'(motion_en), 1);
    cyc();
    check({tag, "_respawn_1clk"}, int'(respawn), 0);
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    // Reset with start held high; releasing reset must not start a game.
    start = 1'b1;
    rst   = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_score", int'(score), 0);
    check("rst_speeds", int'({speed1, speed2, speed3, speed4}), 16'h5344);
    check("rst_motion", int'(motion_en), 0);
    check("rst_respawn", int'(respawn), 0);
    check("rst_over", int'(game_over), 0);

    // Second press starts the game.
    press_start();
    check("start_state", int'(state), 1);
    check("start_respawn", int'(respawn), 1);
    check("start_lives", int'(lives), 3);
    check("start_motion", int'(motion_en), 1);
    cyc();
    check("start_respawn_1clk", int'(respawn), 0);

    // First hit, coincident with a tick that must not count.
    hit  = 1'b1;
    tick = 1'b1;
    cyc();
    hit  = 1'b0;
    tick = 1'b0;
    check("hit1_state", int'(state), 2);
    check("hit1_lives", int'(lives), 2);
    check("hit1_motion", int'(motion_en), 0);
    ride_freeze("hit1");

    pulse_hit();
    check("hit2_lives", int'(lives), 1);
    // finish and start are ignored while frozen.
    finish = 1'b1;
    start  = 1'b1;
    cyc();
    finish = 1'b0;
    start  = 1'b0;
    check("hit2_ignore_finish", int'(score), 0);
    check("hit2_ignore_state", int'(state), 2);
    ride_freeze("hit2");

    pulse_hit();
    check("hit3_state", int'(state), 4);
    check("hit3_lives", int'(lives), 0);
    check("hit3_over", int'(game_over), 1);
    check("hit3_no_respawn", int'(respawn), 0);
    check("hit3_motion", int'(motion_en), 0);

    press_start();
    check("restart_state", int'(state), 1);
    check("restart_lives", int'(lives), 3);
    check("restart_score", int'(score), 0);
    check("restart_over", int'(game_over), 0);
    check("restart_respawn", int'(respawn), 1);

    // Level-ups: model speeds and score independently.
    e_sp1 = 5; e_sp2 = 3; e_sp3 = 4; e_sp4 = 4; e_score = 0;
    for (int n = 1; n <= 17; n++) begin
      cyc();
      finish = 1'b1;
      cyc();
      finish = 1'b0;
      e_score = sat(e_score + 1);
      e_sp1 = sat(e_sp1 + 2);
      e_sp2 = sat(e_sp2 + 2);
      e_sp3 = sat(e_sp3 + 2);
      e_sp4 = sat(e_sp4 + 2);
      check("lvl_state", int'(state), 3);
      check("lvl_score", int'(score), e_score);
      check("lvl_speeds", int'({speed1, speed2, speed3, speed4}),
            (e_sp1 << 12) | (e_sp2 << 8) | (e_sp3 << 4) | e_sp4);
      if (n == 1) begin
        // A hit during the pause is ignored.
        pulse_hit();
        check("lvl_ignore_hit", int'(lives), 3);
        check("lvl1_speeds", int'({speed1, speed2, speed3, speed4}), 16'h7566);
      end
      ticks(29);
      check("lvl_still_paused", int'(state), 3);
      check("lvl_no_early_respawn", int'(respawn), 0);
      ticks(1);
      check("lvl_back_play", int'(state), 1);
      check("lvl_respawn", int'(respawn), 1);
      if (n == 6) begin
        check("lvl6_saturated", int'({speed1, speed2, speed3, speed4}), 16'hFFFF);
      end
    end
    check("score_sat", int'(score), 15);

    // hit and finish together: hit wins.
    pulse_hit();
    ride_freeze("hit4");
    hit    = 1'b1;
    finish = 1'b1;
    cyc();
    hit    = 1'b0;
    finish = 1'b0;
    check("both_state", int'(state), 2);
    check("both_lives", int'(lives), 1);
    check("both_score", int'(score), 15);
    check("both_speeds", int'({speed1, speed2, speed3, speed4}), 16'hFFFF);

    // Async reset mid-freeze (timer at 20), observed before the next edge.
    ticks(40);
    check("pre_rst_state", int'(state), 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_lives", int'(lives), 3);
    check("arst_motion", int'(motion_en), 0);
    check("arst_respawn", int'(respawn), 0);
    check("arst_score", int'(score), 0);
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_idle", int'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
